// File: rtl/out_port_fifo_if.sv
// Controller-side push bus plus per-channel consumer handshake and status for out_port_fifo.
// The slave modport is the FIFO block; the master modport is whoever drives the controller and consumer side.
interface out_port_fifo_if #(
    parameter int DATA_WIDTH = 8,
    parameter int NUM_CH     = 2
);
    localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

    logic                         wr_en;
    logic [CH_W-1:0]              wr_ch;
    logic [DATA_WIDTH-1:0]        data_in;
    logic                         ovf_clr;
    logic [NUM_CH-1:0]            out_valid;
    logic [NUM_CH-1:0]            out_ready;
    logic [NUM_CH*DATA_WIDTH-1:0] out_data;
    logic [NUM_CH-1:0]            full;
    logic [NUM_CH-1:0]            empty;
    logic [NUM_CH-1:0]            ovf;

    modport master (
        output wr_en, wr_ch, data_in, ovf_clr, out_ready,
        input  out_valid, out_data, full, empty, ovf
    );

    modport slave (
        input  wr_en, wr_ch, data_in, ovf_clr, out_ready,
        output out_valid, out_data, full, empty, ovf
    );
endinterface

// File: rtl/out_port_fifo.sv
// Purpose: per-channel output FIFOs fed by the CPU output strobe, each draining over valid/ready (OUT_PORT_OVERWRITE_EN: overwrite oldest on overflow).
// Latency: a word pushed at edge N is on out_data in cycle N+1; a pop at edge N shows the next head in cycle N+1.
// Backpressure: none towards the controller; a push to a full, non-popping channel is dropped (or overwrites) and sets sticky ovf.
module out_port_fifo #(
    parameter int DATA_WIDTH = 8,
    parameter int DEPTH      = 4,
    parameter int NUM_CH     = 2
) (
    input  logic           clk_out,
    input  logic           rst,
    out_port_fifo_if.slave bus
);
    localparam int CH_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);

    for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
        logic [DATA_WIDTH-1:0] r_mem [DEPTH];
        logic [PTR_W-1:0]      r_rd_ptr;
        logic [PTR_W-1:0]      r_wr_ptr;
        logic [CNT_W-1:0]      r_cnt;
        logic                  r_ovf;

        logic w_push;
        logic w_pop;
        logic w_full;
        logic w_empty;
        logic w_ovf_set;
        logic w_wr;
        logic w_adv_rd;

        assign w_empty   = (r_cnt == '0);
        assign w_full    = (r_cnt == CNT_FULL);
        // Out-of-range wr_ch never matches any channel index, so it is ignored.
        assign w_push    = bus.wr_en && (bus.wr_ch == CH_W'(c));
        assign w_pop     = !w_empty && bus.out_ready[c];
        assign w_ovf_set = w_push && w_full && !w_pop;

`ifdef OUT_PORT_OVERWRITE_EN
        // Overflow writes anyway and retires the oldest word to make room.
        assign w_wr      = w_push;
        assign w_adv_rd  = w_pop || w_ovf_set;
`else
        assign w_wr      = w_push && (!w_full || w_pop);
        assign w_adv_rd  = w_pop;
`endif

        always_ff @(posedge clk_out or posedge rst) begin
            if (rst) begin
                r_rd_ptr <= '0;
                r_wr_ptr <= '0;
                r_cnt    <= '0;
                r_ovf    <= 1'b0;
            end else begin
                if (w_wr)
                    r_wr_ptr <= r_wr_ptr + 1'b1;
                if (w_adv_rd)
                    r_rd_ptr <= r_rd_ptr + 1'b1;
                if (w_wr && !w_adv_rd)
                    r_cnt <= r_cnt + 1'b1;
                else if (!w_wr && w_adv_rd)
                    r_cnt <= r_cnt - 1'b1;
                if (w_ovf_set)
                    r_ovf <= 1'b1;
                else if (bus.ovf_clr)
                    r_ovf <= 1'b0;
            end
        end

        // Storage is deliberately left unreset; empty channels mask it on out_data.
        always_ff @(posedge clk_out) begin
            if (w_wr)
                r_mem[r_wr_ptr] <= bus.data_in;
        end

        assign bus.out_data[c*DATA_WIDTH +: DATA_WIDTH] = w_empty ? '0 : r_mem[r_rd_ptr];
        assign bus.out_valid[c] = !w_empty;
        assign bus.empty[c]     = w_empty;
        assign bus.full[c]      = w_full;
        assign bus.ovf[c]       = r_ovf;
    end
endmodule

// File: tb/tb_out_port_fifo.sv
// Randomised and directed bench for out_port_fifo against a queue-based reference model.
module tb_out_port_fifo;
    localparam int DW    = 8;
    localparam int DEPTH = 4;
    localparam int NCH   = 3;
    localparam int CHW   = 2;

    logic clk_out = 1'b0;
    logic rst     = 1'b1;

    out_port_fifo_if #(.DATA_WIDTH(DW), .NUM_CH(NCH)) bus_if ();

    out_port_fifo #(.DATA_WIDTH(DW), .DEPTH(DEPTH), .NUM_CH(NCH)) dut (
        .clk_out (clk_out),
        .rst     (rst),
        .bus     (bus_if)
    );

    always #5 clk_out = ~clk_out;

    int n_chk  = 0;
    int n_fail = 0;

    logic [DW-1:0]  mq [NCH][$];
    logic [NCH-1:0] m_ovf = '0;

    task automatic chk_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, want 0x%0h (t=%0t)", tag, act, exp, $time);
        end
    endtask

    task automatic check_outputs();
        logic [NCH-1:0]    ev, ee, ef;
        logic [NCH*DW-1:0] ed;
        ev = '0; ee = '0; ef = '0; ed = '0;
        for (int c = 0; c < NCH; c++) begin
            ev[c] = (mq[c].size() != 0);
            ee[c] = (mq[c].size() == 0);
            ef[c] = (mq[c].size() == DEPTH);
            if (mq[c].size() != 0)
                ed[c*DW +: DW] = mq[c][0];
        end
        chk_eq("out_valid", 32'(bus_if.out_valid), 32'(ev));
        chk_eq("empty",     32'(bus_if.empty),     32'(ee));
        chk_eq("full",      32'(bus_if.full),      32'(ef));
        chk_eq("ovf",       32'(bus_if.ovf),       32'(m_ovf));
        chk_eq("out_data",  32'(bus_if.out_data),  32'(ed));
    endtask

    // Called at a falling edge: check, drive one cycle of inputs, advance the model, reach next falling edge.
    task automatic step(input logic we, input logic [CHW-1:0] ch, input logic [DW-1:0] d,
                        input logic clr, input logic [NCH-1:0] rdy);
        check_outputs();
        bus_if.wr_en     = we;
        bus_if.wr_ch     = ch;
        bus_if.data_in   = d;
        bus_if.ovf_clr   = clr;
        bus_if.out_ready = rdy;
        for (int c = 0; c < NCH; c++) begin
            bit was_full, pop, push, oset;
            was_full = (mq[c].size() == DEPTH);
            pop      = (mq[c].size() != 0) && rdy[c];
            push     = we && (int'(ch) == c);
            oset     = push && was_full && !pop;
            if (pop)
                void'(mq[c].pop_front());
            if (push && !oset)
                mq[c].push_back(d);
`ifdef OUT_PORT_OVERWRITE_EN
            if (oset) begin
                void'(mq[c].pop_front());
                mq[c].push_back(d);
            end
`endif
            if (oset)
                m_ovf[c] = 1'b1;
            else if (clr)
                m_ovf[c] = 1'b0;
        end
        @(posedge clk_out);
        @(negedge clk_out);
    endtask

    task automatic idle(input logic [NCH-1:0] rdy);
        step(1'b0, '0, '0, 1'b0, rdy);
    endtask

    task automatic push(input logic [CHW-1:0] ch, input logic [DW-1:0] d, input logic [NCH-1:0] rdy);
        step(1'b1, ch, d, 1'b0, rdy);
    endtask

    initial begin
        bus_if.wr_en     = 1'b0;
        bus_if.wr_ch     = '0;
        bus_if.data_in   = '0;
        bus_if.ovf_clr   = 1'b0;
        bus_if.out_ready = '0;
        @(negedge clk_out);
        @(negedge clk_out);
        check_outputs();
        rst = 1'b0;
        @(negedge clk_out);

        // Fill ch0 then drain it.
        push(0, 8'h11, 3'b000);
        push(0, 8'h22, 3'b000);
        push(0, 8'h33, 3'b000);
        push(0, 8'h44, 3'b000);
        chk_eq("fill_full0", 32'(bus_if.full[0]), 32'd1);
        chk_eq("fill_head0", 32'(bus_if.out_data[7:0]), 32'h11);
        for (int i = 0; i < 4; i++) idle(3'b001);
        chk_eq("drain_empty0", 32'(bus_if.empty[0]), 32'd1);
        idle(3'b000);

        // Overflow on ch1, then clear the flag.
        for (int i = 0; i < 4; i++) push(1, 8'hA0 + 8'(i), 3'b000);
        push(1, 8'hFF, 3'b000);
        chk_eq("ovf1_set", 32'(bus_if.ovf[1]), 32'd1);
`ifdef OUT_PORT_OVERWRITE_EN
        chk_eq("ovf1_head", 32'(bus_if.out_data[15:8]), 32'hA1);
`else
        chk_eq("ovf1_head", 32'(bus_if.out_data[15:8]), 32'hA0);
`endif
        for (int i = 0; i < 4; i++) idle(3'b010);
        step(1'b0, '0, '0, 1'b1, 3'b000);
        chk_eq("ovf1_clr", 32'(bus_if.ovf[1]), 32'd0);

        // Full ch0 with simultaneous push and pop while ch1 drains.
        for (int i = 0; i < 4; i++) push(0, 8'hB0 + 8'(i), 3'b000);
        push(1, 8'hD0, 3'b000);
        push(1, 8'hD1, 3'b000);
        push(0, 8'hC0, 3'b011);
        chk_eq("pp_full0", 32'(bus_if.full[0]), 32'd1);
        chk_eq("pp_head0", 32'(bus_if.out_data[7:0]), 32'hB1);
        push(0, 8'hC1, 3'b011);
        chk_eq("pp_ovf0", 32'(bus_if.ovf[0]), 32'd0);

        // Out-of-range channel select.
        push(2'd3, 8'h77, 3'b000);
        for (int i = 0; i < 5; i++) idle(3'b111);

        // Reset mid-drain, including a set ovf flag on ch2.
        for (int i = 0; i < 5; i++) push(2, 8'hE0 + 8'(i), 3'b000);
        push(0, 8'h55, 3'b000);
        push(0, 8'h66, 3'b000);
        idle(3'b001);
        #2;
        rst = 1'b1;
        #1;
        chk_eq("rst_valid_async", 32'(bus_if.out_valid), 32'd0);
        chk_eq("rst_ovf_async", 32'(bus_if.ovf), 32'd0);
        for (int c = 0; c < NCH; c++) mq[c].delete();
        m_ovf = '0;
        @(negedge clk_out);
        check_outputs();
        rst = 1'b0;
        idle(3'b111);
        idle(3'b000);

        // Randomised traffic with alternating consumer pressure.
        for (int i = 0; i < 800; i++) begin
            logic [NCH-1:0] rdy;
            rdy = ((i / 100) % 2 == 1) ? NCH'($urandom) : NCH'($urandom & $urandom & $urandom);
            step(($urandom % 4) != 0, CHW'($urandom % 4), DW'($urandom),
                 ($urandom % 16) == 0, rdy);
        end
        check_outputs();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/out_port_fifo.md
# out_port_fifo

Parametrised, multi-channel output port that replaces the single 8-bit result-display latch in the CPU top level. When the controller strobes an output, the block captures the bus value into a per-channel FIFO. Each channel drains independently to an external consumer (display, UART, LED driver) over a valid/ready handshake, with full/empty status and a sticky overflow flag per channel. It sits between the internal bus and the top-level pins, clocked by the gated CPU clock.

## Interface
- DATA_WIDTH, 8, width of each captured word (taken from bus[DATA_WIDTH-1:0])
- DEPTH, 4, entries per channel FIFO; power of 2, ≥2
- NUM_CH, 2, number of independent output channels; ≥1
- CH_W, derived = max(1, clog2(NUM_CH)), channel select width
- clk_out  in  1  CPU clock; all state updates on rising edge
- rst  in  1  reset, asynchronous, active-high
- wr_en  in  1  controller output strobe; push data_in into channel wr_ch
- wr_ch  in  CH_W  target channel for the push
- data_in  in  DATA_WIDTH  low bits of the internal bus
- ovf_clr  in  1  synchronous clear of all overflow flags
- out_valid  out  NUM_CH  channel c holds at least one word
- out_ready  in  NUM_CH  consumer on channel c accepts the head word
- out_data  out  NUM_CH*DATA_WIDTH  head word of channel c in slice [c*DATA_WIDTH +: DATA_WIDTH]
- full  out  NUM_CH  channel c holds DEPTH words
- empty  out  NUM_CH  channel c holds 0 words
- ovf  out  NUM_CH  sticky: a push hit a full channel c

## Operation
- Each channel has a circular buffer, read pointer, write pointer, and a count of 0..DEPTH (clog2(DEPTH)+1 bits). Pointers wrap modulo DEPTH.
- Push: wr_en=1 and wr_ch<NUM_CH. If wr_ch≥NUM_CH, the push is ignored and no flag is set.
- Pop on channel c: out_valid[c] and out_ready[c]. out_ready is ignored while empty.
- out_valid[c] = !empty[c].
- out_data[c] is combinational from the storage at the read pointer. It is forced to 0 while the channel is empty.
- Push to a non-full channel: write at the write pointer, advance it, count+1.
- Push and pop on the same channel in the same cycle:
  - Not full: both happen, count unchanged.
  - Full: both happen, because the pop frees a slot. Count stays DEPTH and ovf is not set.
- Push to a full channel with no pop is handled per Configuration, and ovf[c] is set.
- Pops on different channels are independent and may occur in the same cycle.
- ovf_clr clears all ovf bits. If an overflow event and ovf_clr occur in the same cycle, the set wins.
- Storage contents are not reset. Only pointers, counts and flags are reset.

## Timing
- Reset values: out_valid=0, empty=all 1, full=0, ovf=0, out_data=0. Pointers and counts are 0.
- Reset mid-operation discards all queued words immediately (asynchronous). No pop is reported after rst.
- Push latency: a word pushed at edge N appears on out_data with out_valid=1 after edge N. This is visible to the consumer in cycle N+1.
- Pop: a handshake sampled at edge N advances the head after edge N. The next word, or 0 if the channel became empty, is shown in cycle N+1.
- Throughput: 1 push (one channel) and 1 pop per channel per cycle.
- full and empty are derived from the registered count and change only after a clock edge.
- While clk_out is gated by hlt, all state freezes. The handshake is evaluated only on clk_out edges.

## Configuration
- OUT_PORT_OVERWRITE_EN
  - Undefined: a push to a full channel with no pop is dropped. Contents, pointers and count are unchanged, and ovf[c] is set.
  - Defined: a push to a full channel with no pop overwrites the oldest word. The word is written at the write pointer, both pointers advance, count stays DEPTH, and ovf[c] is set. The channel then holds the newest DEPTH words.

## Test plan
- Reset, then check idle state: out_valid=00, empty=11, full=00, ovf=00, out_data=0 on all channels.
- Single channel, default params: push 0x11,0x22,0x33,0x44 to ch0 with out_ready=0 → full[0]=1. Then out_ready[0]=1 for 4 cycles → out_data reads 0x11,0x22,0x33,0x44, then empty[0]=1 and out_data=0.
- Overflow, macro undefined: fill ch1 with 0xA0..0xA3, push 0xFF → ovf[1]=1 and the drain yields 0xA0..0xA3. Assert ovf_clr → ovf[1]=0.
- Overflow, macro defined: same stimulus → the drain yields 0xA1,0xA2,0xA3,0xFF and ovf[1]=1.
- Simultaneous push and pop on a full ch0 → count stays 4, ovf[0]=0, and the head advances by one. Meanwhile ch1 drains independently with out_ready[1]=1.
- Push 0x55 to ch0, assert rst mid-drain → out_valid drops immediately and stays 0 after release.
- Push with wr_ch out of range (NUM_CH=3, wr_ch=3) → no state change.
